// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for an N-input AND gate under test: drives every vector, samples, counts mismatches.
// Optional build macro GSWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_sweep_ctrl #(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic [N_IN-1:0]  gate_in_o,
    input  logic             gate_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [N_IN-1:0]  fail_vec_o
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRIVE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [N_IN-1:0]  gate_in_q, gate_in_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]  fail_vec_q, fail_vec_d;
    logic             first_fail_q, first_fail_d;
    logic             mismatch;
    logic             last_vec;

    assign mismatch = (gate_out_i != (&vec_q));
    assign last_vec = (vec_q == {N_IN{1'b1}});

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        gate_in_d    = gate_in_q;
        settle_d     = settle_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        fail_vec_d   = fail_vec_q;
        first_fail_d = first_fail_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_cnt_d    = '0;
                    fail_vec_d   = '0;
                    first_fail_d = 1'b0;
                    pass_d       = 1'b0;
                    vec_d        = '0;
                    state_d      = DRIVE;
                end
            end
            DRIVE: begin
                gate_in_d = vec_q;
                settle_d  = SW'(SETTLE_CYC - 1);
                busy_d    = 1'b1;
                state_d   = SETTLE;
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (!first_fail_q) begin
                        fail_vec_d   = vec_q;
                        first_fail_d = 1'b1;
                    end
                end
`ifdef GSWEEP_STOP_ON_FAIL_EN
                if (mismatch || last_vec) begin
`else
                if (last_vec) begin
`endif
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    state_d = DRIVE;
                end
            end
            DONE: begin
                // err_cnt already holds the final sample's update here
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == '0);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            gate_in_q    <= '0;
            settle_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_vec_q   <= '0;
            first_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            gate_in_q    <= gate_in_d;
            settle_q     <= settle_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            fail_vec_q   <= fail_vec_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign gate_in_o  = gate_in_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign err_cnt_o  = err_cnt_q;
    assign fail_vec_o = fail_vec_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: table of gate models swept on a CNT_W=4 instance,
// plus hand-written sequences for start-while-busy, mid-sweep reset and CNT_W=1 saturation.
module tb_gate_sweep_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstN;
   logic       start;
   logic [1:0] gateIn;
   logic       gateOut;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] errCnt;
   logic [1:0] failVec;

   logic       start1;
   logic [1:0] gateIn1;
   logic       gateOut1;
   logic       busy1;
   logic       done1;
   logic       pass1;
   logic [0:0] errCnt1;
   logic [1:0] failVec1;

   int gateMode;

   // Gate models driven back into the sequencer: 0 AND, 1 OR, 2 stuck-0, 3 stuck-1, 4 NAND
   always_comb begin
      gateOut = 1'b0;
      case (gateMode)
         0: gateOut = &gateIn;
         1: gateOut = |gateIn;
         2: gateOut = 1'b0;
         3: gateOut = 1'b1;
         default: gateOut = ~(&gateIn);
      endcase
   end

   assign gateOut1 = 1'b1;

   gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(1), .CNT_W(4)) dut (
      .clk_i(clk), .rst_ni(rstN), .start_i(start), .gate_in_o(gateIn), .gate_out_i(gateOut),
      .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(errCnt), .fail_vec_o(failVec)
   );

   gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(1), .CNT_W(1)) dutNarrow (
      .clk_i(clk), .rst_ni(rstN), .start_i(start1), .gate_in_o(gateIn1), .gate_out_i(gateOut1),
      .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(errCnt1), .fail_vec_o(failVec1)
   );

   typedef struct {
      int         mode;
      logic [3:0] expErr;
      logic [1:0] expFail;
      logic       expPass;
   } sweepVec_t;

   sweepVec_t vectors[5];

   int checks = 0;
   int errors = 0;

   logic [1:0] seenGate[64];
   logic       seenBusy[64];

   // Compares one observed value against the bench's expectation and logs any disagreement
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   // Launches one sweep with a single-cycle start, optionally re-pulsing start pokeAt negedges later;
   // lat is the number of clock edges from the accepting edge to done, or -1 if it never came
   task automatic applyStimulus(input int pokeAt, output int lat);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int k = 0; k < 60; k++) begin
         seenGate[k] = gateIn;
         seenBusy[k] = busy;
         start = (k == pokeAt);
         if (done) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   // Drives the table, then the multi-cycle corner cases, then prints the summary
   initial begin
      int  lat;
      int  waitCnt;
      logic doneSeen;

      vectors[0] = '{mode: 0, expErr: 4'd0, expFail: 2'b00, expPass: 1'b1};
      vectors[1] = '{mode: 1, expErr: 4'd2, expFail: 2'b01, expPass: 1'b0};
      vectors[2] = '{mode: 2, expErr: 4'd1, expFail: 2'b11, expPass: 1'b0};
      vectors[3] = '{mode: 3, expErr: 4'd3, expFail: 2'b00, expPass: 1'b0};
      vectors[4] = '{mode: 4, expErr: 4'd4, expFail: 2'b00, expPass: 1'b0};

      rstN     = 1'b0;
      start    = 1'b0;
      start1   = 1'b0;
      gateMode = 0;
      #12;
      checkOutput("reset gate_in", 32'(gateIn), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset pass", 32'(pass), 32'd0);
      checkOutput("reset err_cnt", 32'(errCnt), 32'd0);
      checkOutput("reset fail_vec", 32'(failVec), 32'd0);
      @(negedge clk);
      rstN = 1'b1;

      for (int i = 0; i < 5; i++) begin
         gateMode = vectors[i].mode;
         applyStimulus(-1, lat);
         $display("[TB] sweep mode %0d done after %0d cycles", gateMode, lat);
         checkOutput($sformatf("row%0d latency", i), 32'(lat), 32'd13);
         checkOutput($sformatf("row%0d err_cnt", i), 32'(errCnt), 32'(vectors[i].expErr));
         checkOutput($sformatf("row%0d fail_vec", i), 32'(failVec), 32'(vectors[i].expFail));
         checkOutput($sformatf("row%0d pass", i), 32'(pass), 32'(vectors[i].expPass));
         checkOutput($sformatf("row%0d busy at done", i), 32'(busy), 32'd0);
         checkOutput($sformatf("row%0d busy early", i), 32'(seenBusy[1]), 32'd1);
         for (int v = 0; v < 4; v++) begin
            checkOutput($sformatf("row%0d gate_in step%0d", i, v), 32'(seenGate[3 * v + 1]), 32'(v));
         end
         @(negedge clk);
         checkOutput($sformatf("row%0d done pulse width", i), 32'(done), 32'd0);
         checkOutput($sformatf("row%0d gate_in held", i), 32'(gateIn), 32'd3);
      end

      // start pulsed mid-sweep must neither disturb the sweep nor queue another one
      gateMode = 0;
      applyStimulus(5, lat);
      checkOutput("busy-start latency", 32'(lat), 32'd13);
      checkOutput("busy-start pass", 32'(pass), 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("busy-start no relaunch busy", 32'(busy), 32'd0);
      checkOutput("busy-start no relaunch gate_in", 32'(gateIn), 32'd3);

      // reset while gate_in=10 must clear everything at once and never emit done
      gateMode = 1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitCnt = 0;
      while (gateIn != 2'b10 && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("reach gate_in 10", 32'(gateIn), 32'd2);
      checkOutput("err_cnt before reset", 32'(errCnt), 32'd1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("midreset gate_in", 32'(gateIn), 32'd0);
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset err_cnt", 32'(errCnt), 32'd0);
      checkOutput("midreset fail_vec", 32'(failVec), 32'd0);
      checkOutput("midreset pass", 32'(pass), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      doneSeen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) doneSeen = 1'b1;
      end
      checkOutput("no done after reset", 32'(doneSeen), 32'd0);
      gateMode = 0;
      applyStimulus(-1, lat);
      checkOutput("restart first vector", 32'(seenGate[1]), 32'd0);
      checkOutput("restart latency", 32'(lat), 32'd13);
      checkOutput("restart pass", 32'(pass), 32'd1);

      // narrow counter: three mismatches saturate a 1-bit count
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      waitCnt = 0;
      while (!done1 && waitCnt < 40) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("narrow done reached", 32'(done1), 32'd1);
      checkOutput("narrow err_cnt", 32'(errCnt1), 32'd1);
      checkOutput("narrow fail_vec", 32'(failVec1), 32'd0);
      checkOutput("narrow pass", 32'(pass1), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
